data_mem_bytelane: RTL
======================

// Module: data_mem_bytelane
// PURPOSE
// - Parametrised successor of the single-cycle word data memory in the RISC-V datapath; sits behind the MEM stage.
// - Adds RISC-V byte/halfword/word loads and stores with sign/zero extension and byte-lane writes.
// - Adds a sequenced init FSM that preloads or clears every word after reset, plus misalign/range fault detection.
// - Adds a parametrised debug tap bus for the board display logic.
// PARAMETERS
// - DEPTH      256  number of 32-bit words; power of two, 16..4096
// - PRELOAD_EN 1    1: words 0..10 get DMEM_PRELOAD during init; 0: all words cleared
// - TAP_BASE   1    first word index exported on taps
// - N_TAPS     10   number of exported words; TAP_BASE+N_TAPS <= DEPTH
// PORTS
// - clk         in   1            single clock, all logic on posedge
// - reset       in   1            synchronous, active-high
// - addr        in   32           byte address from ALU
// - write_data  in   32           store data; low bytes used for SB/SH
// - memwrite    in   1            store request
// - memread     in   1            load request
// - funct3      in   3            RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - read_data   out  32           extended load result, registered
// - rvalid      out  1            1-cycle pulse: read_data updated
// - busy        out  1            high while init FSM runs; requests ignored
// - misalign    out  1            1-cycle pulse: misaligned/illegal-size access rejected
// - range_err   out  1            1-cycle pulse: addr >= DEPTH*4, access rejected
// - taps        out  32*N_TAPS    word TAP_BASE+k on bits [32k+31:32k], combinational from array
// BEHAVIOUR
// - Reset (clk edge with reset=1):
//   - state<=INIT, init_ptr<=0, busy<=1; read_data, rvalid, misalign, range_err <= 0.
//   - Reset held N cycles keeps init_ptr at 0.
//   - Reset asserted mid-INIT or mid-RUN restarts INIT from word 0.
// - INIT: one word per cycle; MEM[init_ptr] <= (PRELOAD_EN && init_ptr<11) ? DMEM_PRELOAD[init_ptr] : 0.
//   - After word DEPTH-1 is written: state<=RUN, busy<=0. busy is high for exactly DEPTH cycles after reset release.
//   - memread/memwrite ignored in INIT: no write, no rvalid, no fault pulse.
// - RUN, word index = addr[log2(DEPTH)+1:2]:
//   - Checks, in priority order:
//     - addr[31:log2(DEPTH)+2] != 0 -> range_err.
//     - Illegal funct3 (011,110,111), or size H/HU with addr[0]=1, or size W with addr[1:0]!=0 -> misalign.
//   - A rejected access performs no write. A rejected read sets read_data<=0 and still pulses rvalid. Fault flags pulse one cycle.
//   - Store byte enables:
//     - SB: lane addr[1:0], data write_data[7:0].
//     - SH: lanes {addr[1],0} and {addr[1],1}, data write_data[15:0].
//     - SW: all four lanes.
//     - Unenabled lanes keep their old value.
//   - Load: read_data <= extend(lane select of MEM[idx]), 1-cycle latency, rvalid<=1 the same edge.
//     - LB/LH sign-extend; LBU/LHU zero-extend.
//     - read_data holds its value when no read is issued.
//   - memread and memwrite in the same cycle, same word: read returns pre-write contents (read-before-write); the write still commits.
// - taps reflect array contents continuously, including during INIT (partially initialised values visible).
// STRUCTURE
// - Package dmem_pkg holds:
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
//   - DMEM_PRELOAD[0:10] = {10,32,20,12,45,56,21,67,10,2,70}
//   - state encoding INIT=1'b0, RUN=1'b1
// - One sub-module: dmem_lane_align (combinational) — produces byte enables plus aligned write word from funct3/addr[1:0]/write_data, and the extended load from funct3/addr[1:0]/raw word.
// - Top module holds the array, init FSM/counter, fault checks and output registers.
// TESTING
// - Init: reset 3 cycles, release -> busy=1 for exactly DEPTH cycles; then taps word1=32, word10=70; word 200 reads 0.
// - Byte store/load:
//   - SW 0x80FF7F01 @0x40.
//   - LB @0x40 -> 0x00000001; LB @0x41 -> 0x0000007F; LB @0x42 -> 0xFFFFFFFF.
//   - LBU @0x43 -> 0x00000080; LHU @0x42 -> 0x000080FF; LH @0x42 -> 0xFFFF80FF.
// - Lane write: SB 0xAA @0x45 over word 0x11223344 -> LW @0x44 = 0x1122AA44.
// - Faults:
//   - LW @0x42 -> misalign pulse, read_data=0, memory unchanged.
//   - SW @0x400 (DEPTH=256) -> range_err pulse, no write.
//   - funct3=011 -> misalign.
// - Hazard: memread+memwrite SW 0x55 @0x8 (old value 20) -> read_data=20 next cycle; next LW @0x8 -> 0x55.
// - Reset mid-INIT at ptr 100 -> busy stays high DEPTH more cycles; requests during INIT produce no rvalid and no writes.

Source files
------------

// File: rtl/data_mem_bytelane_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-lane data memory: RISC-V load/store size
// codes, the preload image for the low words, the init/run state encoding and
// small helper functions for access legality and preload lookup.
// ---------------------------------------------------------------------------
package dmem_pkg;

    // RISC-V funct3 size codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned N_PRELOAD = 11;

    // Image loaded into words 0..10 when preloading is enabled
    localparam logic [31:0] DMEM_PRELOAD [0:10] = '{
        32'd10, 32'd32, 32'd20, 32'd12, 32'd45, 32'd56,
        32'd21, 32'd67, 32'd10, 32'd2,  32'd70
    };

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // Preload word for a low word index; indices past the image read as zero
    function automatic logic [31:0] preload_word(input logic [3:0] idx);
        logic [31:0] word;
        if (idx < 4'd11) begin
            word = DMEM_PRELOAD[idx];
        end else begin
            word = 32'd0;
        end
        return word;
    endfunction

    // 1 when the size code is undefined or the byte offset breaks natural alignment
    function automatic logic access_illegal(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_bytelane_if.sv
// ---------------------------------------------------------------------------
// data_mem_bytelane_if
// MEM-stage bus between the datapath (master) and the data memory (slave).
//   addr/write_data/memwrite/memread/funct3 : request from the datapath
//   read_data/rvalid                        : registered load result + strobe
//   busy                                    : memory still initialising
//   misalign/range_err                      : one-cycle fault pulses
// ---------------------------------------------------------------------------
interface data_mem_bytelane_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [2:0]  funct3;
    logic [31:0] read_data;
    logic        rvalid;
    logic        busy;
    logic        misalign;
    logic        range_err;

    modport master (
        output addr, write_data, memwrite, memread, funct3,
        input  read_data, rvalid, busy, misalign, range_err
    );

    modport slave (
        input  addr, write_data, memwrite, memread, funct3,
        output read_data, rvalid, busy, misalign, range_err
    );
endinterface

// File: rtl/data_mem_bytelane_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering for the data memory.
//   funct3, addr_lo : access size and byte offset within the word
//   write_data      : store data, low bytes significant for SB/SH
//   raw_word        : word currently held at the addressed index
//   byte_en         : lanes to update on a store
//   wdata_aligned   : store data replicated so each enabled lane sees its byte
//   load_ext        : selected lane(s) of raw_word, sign/zero extended
// Legality is judged by the caller; this block only steers bytes.
// ---------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] write_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_aligned,
    output logic [31:0] load_ext
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: only funct3[1:0] carries the size for stores
    always_comb begin
        byte_en       = 4'b0000;
        wdata_aligned = 32'd0;
        case (funct3[1:0])
            2'b00: begin
                byte_en       = 4'b0001 << addr_lo;
                wdata_aligned = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{write_data[15:0]}};
            end
            2'b10: begin
                byte_en       = 4'b1111;
                wdata_aligned = write_data;
            end
            default: begin
                byte_en       = 4'b0000;
                wdata_aligned = 32'd0;
            end
        endcase
    end

    // Load side: shift the addressed byte down to lane 0, then extend
    always_comb begin
        shifted_s = raw_word >> {addr_lo, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        case (funct3)
            F3_B:    load_ext = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_ext = {24'd0, byte_s};
            F3_H:    load_ext = {{16{half_s[15]}}, half_s};
            F3_HU:   load_ext = {16'd0, half_s};
            F3_W:    load_ext = raw_word;
            default: load_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// ---------------------------------------------------------------------------
// data_mem_bytelane
// Word-organised data memory behind the MEM stage with RISC-V byte/half/word
// loads and stores, a post-reset init sequencer that writes every word once,
// misalign/range fault detection and a debug tap bus.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of data_mem_bytelane_if (request, result, faults)
//   taps       : word TAP_BASE+k on bits [32k+31:32k], straight from the array
// ---------------------------------------------------------------------------
module data_mem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter bit          PRELOAD_EN = 1'b1,
    parameter int unsigned TAP_BASE   = 1,
    parameter int unsigned N_TAPS     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    data_mem_bytelane_if.slave      bus,
    output logic [32*N_TAPS-1:0]    taps
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];

    dmem_state_e state_q, state_d;
    logic [AW-1:0] init_ptr_q, init_ptr_d;
    logic        busy_q, busy_d;
    logic [31:0] read_data_q, read_data_d;
    logic        rvalid_q, rvalid_d;
    logic        misalign_q, misalign_d;
    logic        range_err_q, range_err_d;

    logic          mem_we_s;
    logic [AW-1:0] mem_widx_s;
    logic [3:0]    mem_be_s;
    logic [31:0]   mem_wdata_s;

    logic [AW-1:0] idx_s;
    logic [31:0]   raw_word_s;
    logic [3:0]    lane_be_s;
    logic [31:0]   lane_wdata_s;
    logic [31:0]   load_ext_s;
    logic          out_of_range_s;
    logic          illegal_s;

    assign idx_s          = bus.addr[AW+1:2];
    assign raw_word_s     = mem_q[idx_s];
    assign out_of_range_s = |bus.addr[31:AW+2];
    assign illegal_s      = access_illegal(bus.funct3, bus.addr[1:0]);

    dmem_lane_align u_lane_align (
        .funct3        (bus.funct3),
        .addr_lo       (bus.addr[1:0]),
        .write_data    (bus.write_data),
        .raw_word      (raw_word_s),
        .byte_en       (lane_be_s),
        .wdata_aligned (lane_wdata_s),
        .load_ext      (load_ext_s)
    );

    // Next-state, array write request and output register inputs
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        busy_d      = busy_q;
        read_data_d = read_data_q;
        rvalid_d    = 1'b0;
        misalign_d  = 1'b0;
        range_err_d = 1'b0;
        mem_we_s    = 1'b0;
        mem_widx_s  = init_ptr_q;
        mem_be_s    = 4'b0000;
        mem_wdata_s = 32'd0;
        case (state_q)
            INIT: begin
                // Bus requests are ignored; one whole word written per cycle
                mem_we_s   = 1'b1;
                mem_widx_s = init_ptr_q;
                mem_be_s   = 4'b1111;
                if (PRELOAD_EN && (init_ptr_q < AW'(N_PRELOAD))) begin
                    mem_wdata_s = preload_word(init_ptr_q[3:0]);
                end else begin
                    mem_wdata_s = 32'd0;
                end
                if (init_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end else begin
                    init_ptr_d = init_ptr_q + AW'(1);
                end
            end
            RUN: begin
                if (bus.memread || bus.memwrite) begin
                    // Range fault outranks misalignment
                    if (out_of_range_s) begin
                        range_err_d = 1'b1;
                    end else if (illegal_s) begin
                        misalign_d = 1'b1;
                    end else if (bus.memwrite) begin
                        mem_we_s    = 1'b1;
                        mem_widx_s  = idx_s;
                        mem_be_s    = lane_be_s;
                        mem_wdata_s = lane_wdata_s;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    if (bus.memread) begin
                        // Pre-write contents: read-before-write on a shared word
                        rvalid_d = 1'b1;
                        if (out_of_range_s || illegal_s) begin
                            read_data_d = 32'd0;
                        end else begin
                            read_data_d = load_ext_s;
                        end
                    end else begin
                        read_data_d = read_data_q;
                    end
                end else begin
                    read_data_d = read_data_q;
                end
            end
            default: begin
                state_d    = INIT;
                init_ptr_d = '0;
                busy_d     = 1'b1;
            end
        endcase
    end

    // Control state and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            busy_q      <= 1'b1;
            read_data_q <= 32'd0;
            rvalid_q    <= 1'b0;
            misalign_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            busy_q      <= busy_d;
            read_data_q <= read_data_d;
            rvalid_q    <= rvalid_d;
            misalign_q  <= misalign_d;
            range_err_q <= range_err_d;
        end
    end

    // Storage array; contents survive reset and are rewritten by INIT
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[mem_widx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.busy      = busy_q;
    assign bus.misalign  = misalign_q;
    assign bus.range_err = range_err_q;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_taps
        assign taps[32*k +: 32] = mem_q[TAP_BASE + k];
    end

endmodule
